// File: rtl/deco_pkg.sv
// Shared types and index helpers for the sequenced one-hot decoder.
package deco_pkg;

    localparam int unsigned MaxSelW = 8;
    localparam int unsigned IdxW    = 3;
    localparam int unsigned MaxOutW = 1 << MaxSelW;

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StScan
    } state_e;

    // Bit-reverse over the low w bits only; upper bits stay zero.
    function automatic logic [MaxSelW-1:0] sel2idx(logic [MaxSelW-1:0] sel, int unsigned w,
                                                   logic rev);
        logic [MaxSelW-1:0] idx;
        idx = sel;
        if (rev) begin
            idx = '0;
            for (int i = 0; i < MaxSelW; i++) begin
                if (i < int'(w)) idx[IdxW'(i)] = sel[IdxW'(int'(w) - 1 - i)];
            end
        end
        return idx;
    endfunction

    function automatic logic [MaxOutW-1:0] onehot(logic [MaxSelW-1:0] idx);
        return MaxOutW'(1) << idx;
    endfunction

endpackage

// File: rtl/deco_seq_onehot_if.sv
// Command and select-output bundle of the sequenced one-hot decoder.
interface deco_seq_onehot_if #(
    parameter int unsigned SEL_W  = 2,
    parameter int unsigned HOLD_W = 8
);
    localparam int unsigned OUT_W = 1 << SEL_W;

    logic              en;
    logic              mode;
    logic              in_valid;
    logic              in_ready;
    logic [SEL_W-1:0]  in_sel;
    logic [HOLD_W-1:0] hold_cycles;
    logic [OUT_W-1:0]  out;
    logic              out_valid;
    logic              wrap;

    modport master (
        output en, mode, in_valid, in_sel, hold_cycles,
        input  in_ready, out, out_valid, wrap
    );

    modport slave (
        input  en, mode, in_valid, in_sel, hold_cycles,
        output in_ready, out, out_valid, wrap
    );

endinterface

// File: rtl/deco_dwell_cnt.sv
// Loadable dwell down-counter; last_o flags the final cycle of a dwell.
module deco_dwell_cnt #(
    parameter int unsigned HOLD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [HOLD_W-1:0] val_i,
    input  logic              dec_i,
    output logic              last_o
);
    logic [HOLD_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - HOLD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last_o = (count_q == HOLD_W'(1));

endmodule

// File: rtl/deco_seq_onehot.sv
// Registered binary-to-one-hot decoder with dwell timing and a walking-one scan mode.
module deco_seq_onehot
    import deco_pkg::*;
#(
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned HOLD_W  = 8,
    parameter int unsigned REV_SEL = 1
) (
    input logic              clk,
    input logic              rst_n,
    deco_seq_onehot_if.slave bus
);
    localparam int unsigned OUT_W = 1 << SEL_W;

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  idx_q, idx_d, idx_start, idx_next;
    logic [HOLD_W-1:0] hold_q, hold_d, hold_eff, cnt_val;
    logic [OUT_W-1:0]  out_q, out_d;
    logic              wrap_q, wrap_d;
    logic              accept, cnt_clr, cnt_load, cnt_dec, cnt_last;

    assign idx_start = SEL_W'(sel2idx(MaxSelW'(bus.in_sel), SEL_W, REV_SEL != 0));
    assign idx_next  = idx_q + SEL_W'(1);
    assign hold_eff  = (bus.hold_cycles == '0) ? HOLD_W'(1) : bus.hold_cycles;

    assign bus.in_ready = bus.en && (state_q == StIdle);
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        hold_d   = hold_q;
        out_d    = out_q;
        wrap_d   = 1'b0;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = hold_q;
        unique case (state_q)
            StIdle: begin
                out_d = '0;
                if (accept) begin
                    state_d  = bus.mode ? StScan : StHold;
                    idx_d    = idx_start;
                    hold_d   = hold_eff;
                    out_d    = OUT_W'(onehot(MaxSelW'(idx_start)));
                    cnt_load = 1'b1;
                    cnt_val  = hold_eff;
                end
            end
            StHold: begin
                if (!bus.en || cnt_last) begin
                    state_d = StIdle;
                    out_d   = '0;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StScan: begin
                // Mode is re-checked only at a dwell boundary so the current output finishes.
                if (!bus.en || (cnt_last && !bus.mode)) begin
                    state_d = StIdle;
                    out_d   = '0;
                    cnt_clr = 1'b1;
                end else if (cnt_last) begin
                    idx_d    = idx_next;
                    out_d    = OUT_W'(onehot(MaxSelW'(idx_next)));
                    wrap_d   = (idx_q == '1);
                    cnt_load = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                out_d   = '0;
                cnt_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            hold_q  <= '0;
            out_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            out_q   <= out_d;
            wrap_q  <= wrap_d;
        end
    end

    deco_dwell_cnt #(
        .HOLD_W(HOLD_W)
    ) u_dwell_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr),
        .load_i(cnt_load),
        .val_i (cnt_val),
        .dec_i (cnt_dec),
        .last_o(cnt_last)
    );

    assign bus.out       = out_q;
    assign bus.out_valid = (state_q != StIdle);
    assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_deco_seq_onehot.sv
// Three decoder instances (2-bit reversed, 2-bit direct, 3-bit direct) against an arithmetic model.
module tb_deco_seq_onehot;

    localparam int NDut = 3;

    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic       en_v    [NDut];
    logic       mode_v  [NDut];
    logic       valid_v [NDut];
    logic [2:0] sel_v   [NDut];
    logic [7:0] hold_v  [NDut];
    logic [7:0] out_v   [NDut];
    logic       ready_v [NDut];
    logic       oval_v  [NDut];
    logic       wrap_v  [NDut];

    deco_seq_onehot_if #(.SEL_W(2), .HOLD_W(8)) if_a ();
    deco_seq_onehot_if #(.SEL_W(2), .HOLD_W(8)) if_b ();
    deco_seq_onehot_if #(.SEL_W(3), .HOLD_W(8)) if_c ();

    deco_seq_onehot #(.SEL_W(2), .HOLD_W(8), .REV_SEL(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a));
    deco_seq_onehot #(.SEL_W(2), .HOLD_W(8), .REV_SEL(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b));
    deco_seq_onehot #(.SEL_W(3), .HOLD_W(8), .REV_SEL(0)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .bus(if_c));

    assign if_a.en = en_v[0];  assign if_a.mode = mode_v[0];  assign if_a.in_valid = valid_v[0];
    assign if_b.en = en_v[1];  assign if_b.mode = mode_v[1];  assign if_b.in_valid = valid_v[1];
    assign if_c.en = en_v[2];  assign if_c.mode = mode_v[2];  assign if_c.in_valid = valid_v[2];
    assign if_a.in_sel = sel_v[0][1:0];  assign if_a.hold_cycles = hold_v[0];
    assign if_b.in_sel = sel_v[1][1:0];  assign if_b.hold_cycles = hold_v[1];
    assign if_c.in_sel = sel_v[2];       assign if_c.hold_cycles = hold_v[2];

    assign out_v[0] = {4'b0, if_a.out};  assign ready_v[0] = if_a.in_ready;
    assign out_v[1] = {4'b0, if_b.out};  assign ready_v[1] = if_b.in_ready;
    assign out_v[2] = if_c.out;          assign ready_v[2] = if_c.in_ready;
    assign oval_v[0] = if_a.out_valid;   assign wrap_v[0] = if_a.wrap;
    assign oval_v[1] = if_b.out_valid;   assign wrap_v[1] = if_b.wrap;
    assign oval_v[2] = if_c.out_valid;   assign wrap_v[2] = if_c.wrap;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // Model: a busy command is (start index, dwell h, scan flag, k = cycles since out began).
    bit m_busy [NDut];
    bit m_scan [NDut];
    int m_start[NDut];
    int m_h    [NDut];
    int m_k    [NDut];

    function automatic int sel_w(int i);
        return (i == 2) ? 3 : 2;
    endfunction

    function automatic int ref_idx(int i, logic [2:0] sel);
        int w = sel_w(i);
        int s = int'(sel) & ((1 << w) - 1);
        int r = 0;
        if (i != 0) return s;
        for (int b = 0; b < w; b++) begin
            if (((s >> b) & 1) == 1) r = r | (1 << (w - 1 - b));
        end
        return r;
    endfunction

    function automatic int cur_idx(int i);
        if (!m_scan[i]) return m_start[i];
        return (m_start[i] + m_k[i] / m_h[i]) % (1 << sel_w(i));
    endfunction

    function automatic logic [7:0] exp_out(int i);
        if (!m_busy[i]) return 8'h00;
        return 8'(1 << cur_idx(i));
    endfunction

    function automatic logic exp_wrap(int i);
        return m_busy[i] && m_scan[i] && (m_k[i] > 0) && (m_k[i] % m_h[i] == 0) &&
               (cur_idx(i) == 0);
    endfunction

    task automatic model_step();
        for (int i = 0; i < NDut; i++) begin
            if (!rst_n) begin
                m_busy[i] = 1'b0;
            end else if (!m_busy[i]) begin
                if (en_v[i] && valid_v[i]) begin
                    m_busy[i]  = 1'b1;
                    m_scan[i]  = mode_v[i];
                    m_start[i] = ref_idx(i, sel_v[i]);
                    m_h[i]     = (hold_v[i] == 8'd0) ? 1 : int'(hold_v[i]);
                    m_k[i]     = 0;
                end
            end else if (!en_v[i]) begin
                m_busy[i] = 1'b0;
            end else if ((m_k[i] % m_h[i] == m_h[i] - 1) && (!m_scan[i] || !mode_v[i])) begin
                m_busy[i] = 1'b0;
            end else begin
                m_k[i]++;
            end
        end
    endtask

    string nm [NDut] = '{"a", "b", "c"};

    task automatic check_all();
        for (int i = 0; i < NDut; i++) begin
            check_val({"out_", nm[i]}, 32'(out_v[i]), 32'(exp_out(i)));
            check_val({"out_valid_", nm[i]}, 32'(oval_v[i]), 32'(m_busy[i]));
            check_val({"wrap_", nm[i]}, 32'(wrap_v[i]), 32'(exp_wrap(i)));
            check_val({"in_ready_", nm[i]}, 32'(ready_v[i]), 32'(en_v[i] && !m_busy[i]));
            check_val({"onehot0_", nm[i]}, 32'($onehot0(out_v[i])), 32'd1);
            check_val({"valid_vs_out_", nm[i]}, 32'(oval_v[i]), 32'(out_v[i] != 8'h00));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    // Presents one command for one clock, then drops in_valid.
    task automatic cmd(input int i, input logic mode, input logic [2:0] sel, input logic [7:0] hold);
        en_v[i] = 1'b1; valid_v[i] = 1'b1; mode_v[i] = mode; sel_v[i] = sel; hold_v[i] = hold;
        cycle();
        valid_v[i] = 1'b0;
    endtask

    logic [7:0] scan_out [6] = '{8'h8, 8'h8, 8'h1, 8'h1, 8'h2, 8'h2};
    logic       scan_wrp [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        int on_cnt;
        rst_n = 1'b0;
        for (int i = 0; i < NDut; i++) begin
            en_v[i] = 1'b0; mode_v[i] = 1'b0; valid_v[i] = 1'b0; sel_v[i] = '0; hold_v[i] = '0;
        end
        cycle();
        check_val("rst_out_a", 32'(out_v[0]), 32'h0);
        check_val("rst_wrap_a", 32'(wrap_v[0]), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NDut; i++) en_v[i] = 1'b1;
        cycle();

        // DIRECT, reversed mapping: 2'b10 -> out[1] for three cycles.
        cmd(0, 1'b0, 3'b010, 8'd3);
        check_val("t1_c1", 32'(out_v[0]), 32'h2);
        cycle(); check_val("t1_c2", 32'(out_v[0]), 32'h2);
        cycle(); check_val("t1_c3", 32'(out_v[0]), 32'h2);
        cycle(); check_val("t1_end", 32'(out_v[0]), 32'h0);
        check_val("t1_ready", 32'(ready_v[0]), 32'h1);

        // DIRECT, plain mapping, hold 0 acts as 1.
        cmd(1, 1'b0, 3'b010, 8'd0);
        check_val("t2_c1", 32'(out_v[1]), 32'h4);
        cycle(); check_val("t2_end", 32'(out_v[1]), 32'h0);

        // SCAN from 2'b11 (index 3), dwell 2, then drop mode mid-dwell.
        cmd(0, 1'b1, 3'b011, 8'd2);
        for (int j = 0; j < 6; j++) begin
            check_val("t3_out", 32'(out_v[0]), 32'(scan_out[j]));
            check_val("t3_wrap", 32'(wrap_v[0]), 32'(scan_wrp[j]));
            cycle();
        end
        check_val("t4_first", 32'(out_v[0]), 32'h4);
        mode_v[0] = 1'b0;
        cycle(); check_val("t4_finish", 32'(out_v[0]), 32'h4);
        cycle(); check_val("t4_idle", 32'(out_v[0]), 32'h0);
        check_val("t4_nowrap", 32'(wrap_v[0]), 32'h0);

        // en low three cycles into a 10-cycle hold; in_valid held high must not accept.
        cmd(0, 1'b0, 3'b000, 8'd10);
        cycle(); cycle();
        en_v[0] = 1'b0; valid_v[0] = 1'b1;
        cycle(); check_val("t5_abort", 32'(out_v[0]), 32'h0);
        cycle(); check_val("t5_noacc", 32'(oval_v[0]), 32'h0);
        valid_v[0] = 1'b0; en_v[0] = 1'b1;
        cycle();

        // Async reset between edges mid-scan, then a fresh command.
        cmd(0, 1'b1, 3'b000, 8'd3);
        cycle(); cycle(); cycle();
        #2 rst_n = 1'b0;
        #1;
        check_val("t6_out_async", 32'(out_v[0]), 32'h0);
        check_val("t6_oval_async", 32'(oval_v[0]), 32'h0);
        cycle();
        rst_n = 1'b1;
        cmd(0, 1'b0, 3'b001, 8'd2);
        check_val("t6_new_c1", 32'(out_v[0]), 32'h4);
        cycle(); check_val("t6_new_c2", 32'(out_v[0]), 32'h4);
        cycle(); check_val("t6_new_end", 32'(out_v[0]), 32'h0);

        // Maximum dwell on the 3-bit instance.
        cmd(2, 1'b0, 3'b101, 8'hFF);
        check_val("max_first", 32'(out_v[2]), 32'h20);
        on_cnt = 0;
        for (int j = 0; j < 300; j++) begin
            if (out_v[2] != 8'h00) on_cnt++;
            cycle();
        end
        check_val("max_dwell", 32'(on_cnt), 32'd255);

        // Random stress on all three instances.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NDut; i++) begin
                en_v[i]    = ($urandom_range(0, 15) != 0);
                valid_v[i] = ($urandom_range(0, 2) == 0);
                mode_v[i]  = ($urandom_range(0, 3) != 0);
                sel_v[i]   = 3'($urandom);
                hold_v[i]  = ($urandom_range(0, 31) == 0) ? 8'($urandom) : 8'($urandom_range(0, 4));
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
